// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and geometry helpers for the register file
package rf_pkg;
   localparam int N_DEF     = 32;
   localparam int AW_DEF    = 5;
   localparam int ZERO_ADDR = 0;
   function automatic int depth(input int aw);
      return 1 << aw;
   endfunction
endpackage

// File: rtl/mux_pow2_nbit.sv
// mux_pow2_nbit: balanced 2^AW:1 N-bit read multiplexer
module mux_pow2_nbit
   import rf_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int AW = AW_DEF
) (
   input  logic [N-1:0]  d_i [depth(AW)],
   input  logic [AW-1:0] sel_i,
   output logic [N-1:0]  y_o
);
   // direct index keeps the selection a flat tree rather than a priority chain
   always_comb y_o = d_i[sel_i];
endmodule

// File: rtl/reg_file_nbit.sv
// reg_file_nbit: 2^AW x N register file, one sync write port, two comb read ports
module reg_file_nbit
   import rf_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int AW       = AW_DEF,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          WE,
   input  logic [AW-1:0] WA,
   input  logic [N-1:0]  WD,
   input  logic [AW-1:0] RA0,
   input  logic [AW-1:0] RA1,
   output logic [N-1:0]  RD0,
   output logic [N-1:0]  RD1
);
   localparam int            DEPTH = depth(AW);
   localparam logic [AW-1:0] ZA    = AW'(ZERO_ADDR);
   localparam bit            ZR    = ZERO_REG != 0;
   localparam bit            BP    = BYPASS != 0;
   logic [N-1:0] mem_q [DEPTH];
   logic [N-1:0] mux0, mux1;
   logic         wr_en, zr0, zr1, byp0, byp1;
   // qualify writes, zero-register hits and forwarding matches
   always_comb begin
      wr_en = WE && !(ZR && WA == ZA);
      zr0   = ZR && RA0 == ZA;
      zr1   = ZR && RA1 == ZA;
      byp0  = BP && rst_n && WE && WA == RA0;
      byp1  = BP && rst_n && WE && WA == RA1;
   end
   // storage: reset clears every entry and overrides any write in the same cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[WA] <= WD;
      end
   end
   mux_pow2_nbit #(.N(N), .AW(AW)) u_mux0 (.d_i(mem_q), .sel_i(RA0), .y_o(mux0));
   mux_pow2_nbit #(.N(N), .AW(AW)) u_mux1 (.d_i(mem_q), .sel_i(RA1), .y_o(mux1));
   // zero register wins over forwarding, which wins over stored data
   always_comb begin
      RD0 = zr0 ? '0 : byp0 ? WD : mux0;
      RD1 = zr1 ? '0 : byp1 ? WD : mux1;
   end
endmodule

// File: tb/tb_reg_file_nbit.sv
// tb_reg_file_nbit: random and directed checks of three register file configurations
module tb_reg_file_nbit;
   logic        clk = 0;
   logic        rst_n, we, wec;
   logic [4:0]  wa, ra0, ra1;
   logic [31:0] wd, rd0a, rd1a, rd0b, rd1b;
   logic [2:0]  wac, ra0c, ra1c;
   logic [7:0]  wdc, rd0c, rd1c;
   logic [31:0] ma [32], mb [32];
   logic [7:0]  mc [8];
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   reg_file_nbit u_a (.clk(clk), .rst_n(rst_n), .WE(we), .WA(wa), .WD(wd),
      .RA0(ra0), .RA1(ra1), .RD0(rd0a), .RD1(rd1a));
   reg_file_nbit #(.BYPASS(0)) u_b (.clk(clk), .rst_n(rst_n), .WE(we), .WA(wa), .WD(wd),
      .RA0(ra0), .RA1(ra1), .RD0(rd0b), .RD1(rd1b));
   reg_file_nbit #(.N(8), .AW(3)) u_c (.clk(clk), .rst_n(rst_n), .WE(wec), .WA(wac), .WD(wdc),
      .RA0(ra0c), .RA1(ra1c), .RD0(rd0c), .RD1(rd1c));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ea(input logic [4:0] ra);
      if (ra == 0) return 0;
      if (rst_n && we && wa == ra) return wd;
      return ma[ra];
   endfunction

   function automatic logic [31:0] eb(input logic [4:0] ra);
      return ra == 0 ? 32'h0 : mb[ra];
   endfunction

   function automatic logic [31:0] ec(input logic [2:0] ra);
      if (ra == 0) return 0;
      if (rst_n && wec && wac == ra) return {24'h0, wdc};
      return {24'h0, mc[ra]};
   endfunction

   task automatic chk_all();
      #4;
      chk("a_rd0", rd0a, ea(ra0));
      chk("a_rd1", rd1a, ea(ra1));
      chk("b_rd0", rd0b, eb(ra0));
      chk("b_rd1", rd1b, eb(ra1));
      chk("c_rd0", {24'h0, rd0c}, ec(ra0c));
      chk("c_rd1", {24'h0, rd1c}, ec(ra1c));
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin ma[i] = 0; mb[i] = 0; end
         for (int i = 0; i < 8; i++) mc[i] = 0;
      end else begin
         if (we && wa != 0) begin ma[wa] = wd; mb[wa] = wd; end
         if (wec && wac != 0) mc[wac] = wdc;
      end
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin ma[i] = 0; mb[i] = 0; end
      for (int i = 0; i < 8; i++) mc[i] = 0;
      rst_n = 0; we = 0; wa = 0; wd = 0; ra0 = 0; ra1 = 0;
      wec = 0; wac = 0; wdc = 0; ra0c = 0; ra1c = 0;
      tick();
      rst_n = 1;
      chk_all();
      tick();
      for (int i = 1; i < 32; i++) begin
         we = 1; wa = 5'(i); wd = 32'hFFFFFFFF; ra0 = 5'(i); ra1 = 5'(i);
         chk_all();
         tick();
      end
      rst_n = 0; we = 1; wa = 3; wd = 32'h0000CAFE; ra0 = 3; ra1 = 3;
      chk_all();
      chk("rst_nobyp", rd0a, 32'hFFFFFFFF);
      tick();
      rst_n = 1; we = 0;
      for (int i = 0; i < 32; i++) begin
         ra0 = 5'(i); ra1 = 5'(31 - i);
         chk_all();
         chk("rst_clr0", rd0a, 32'h0);
         chk("rst_clr1", rd1b, 32'h0);
         tick();
      end
      we = 1; wa = 5; wd = 32'hDEADBEEF; ra0 = 1; ra1 = 2;
      chk_all();
      tick();
      we = 0; ra0 = 5; ra1 = 5;
      chk_all();
      chk("wr5_a", rd0a, 32'hDEADBEEF);
      chk("wr5_b", rd1b, 32'hDEADBEEF);
      tick();
      we = 1; wa = 0; wd = 32'h12345678; ra0 = 0; ra1 = 0;
      chk_all();
      chk("zero_now", rd0a, 32'h0);
      tick();
      we = 0;
      chk_all();
      chk("zero_after", rd0a, 32'h0);
      tick();
      we = 1; wa = 7; wd = 32'h1;
      tick();
      wd = 32'hA5A5A5A5; ra1 = 7;
      chk_all();
      chk("byp_a", rd1a, 32'hA5A5A5A5);
      chk("nobyp_b", rd1b, 32'h1);
      tick();
      we = 0;
      chk_all();
      chk("after_b", rd1b, 32'hA5A5A5A5);
      tick();
      we = 1; wa = 3; wd = 32'h1;
      tick();
      rst_n = 0; wd = 32'h0000CAFE; ra0 = 3;
      chk_all();
      chk("rst_byp_off", rd0a, 32'h1);
      tick();
      rst_n = 1; we = 0;
      chk_all();
      chk("rst_beats_wr", rd0a, 32'h0);
      tick();
      for (int i = 1; i < 8; i++) begin
         wec = 1; wac = 3'(i); wdc = 8'(i * 17); ra0c = 3'(i); ra1c = 0;
         chk_all();
         tick();
      end
      wec = 0;
      for (int i = 0; i < 8; i++) begin
         ra0c = 3'(i); ra1c = 3'(i);
         chk_all();
         chk("sweep0", {24'h0, rd0c}, 32'(i * 17));
         chk("sweep1", {24'h0, rd1c}, 32'(i * 17));
         tick();
      end
      for (int n = 0; n < 400; n++) begin
         rst_n = $urandom_range(0, 39) != 0;
         we = 1'($urandom); wa = 5'($urandom); wd = $urandom;
         ra0 = $urandom_range(0, 3) == 0 ? wa : 5'($urandom);
         ra1 = $urandom_range(0, 3) == 0 ? wa : 5'($urandom);
         wec = 1'($urandom); wac = 3'($urandom); wdc = 8'($urandom);
         ra0c = $urandom_range(0, 3) == 0 ? wac : 3'($urandom);
         ra1c = 3'($urandom);
         chk_all();
         tick();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
